// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
//   Bundle between the ID stage (control mux + decode datapath), the ID/EX
//   pipeline register, and the EX stage.
//
//   ID side (driven by master):
//     flush, hold, valid_id        - squash / back-pressure / slot-valid
//     write, MemtoReg, MemRead,
//     MemWrite, regdst, ALUsrc     - stall-gated control bits
//     ALUop[1:0]                   - stall-gated ALU operation class
//     pc4_id, rdata1_id, rdata2_id,
//     imm_id [DW-1:0]              - ID datapath fields
//     rs_id, rt_id, rd_id [4:0]    - register specifiers
//     funct_id [5:0]               - function field
//   EX side (driven by slave, the pipeline register):
//     *_ex                         - registered copies of the ID fields
//     valid_ex                     - EX slot holds a real instruction
//     load_use_stall               - combinational stall to control mux/PC/IF-ID
//     stall_count [CNT_W-1:0]      - saturating count of inserted bubbles
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  // ID side
  logic             flush;
  logic             hold;
  logic             valid_id;
  logic             write;
  logic             MemtoReg;
  logic             MemRead;
  logic             MemWrite;
  logic             regdst;
  logic             ALUsrc;
  logic [1:0]       ALUop;
  logic [DW-1:0]    pc4_id;
  logic [DW-1:0]    rdata1_id;
  logic [DW-1:0]    rdata2_id;
  logic [DW-1:0]    imm_id;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic [4:0]       rd_id;
  logic [5:0]       funct_id;

  // EX side
  logic             write_ex;
  logic             MemtoReg_ex;
  logic             MemRead_ex;
  logic             MemWrite_ex;
  logic             regdst_ex;
  logic             ALUsrc_ex;
  logic [1:0]       ALUop_ex;
  logic [DW-1:0]    pc4_ex;
  logic [DW-1:0]    rdata1_ex;
  logic [DW-1:0]    rdata2_ex;
  logic [DW-1:0]    imm_ex;
  logic [4:0]       rs_ex;
  logic [4:0]       rt_ex;
  logic [4:0]       rd_ex;
  logic [5:0]       funct_ex;
  logic             valid_ex;
  logic             load_use_stall;
  logic [CNT_W-1:0] stall_count;

  // Environment: drives ID fields, observes EX fields
  modport master (
    output flush, hold, valid_id,
    output write, MemtoReg, MemRead, MemWrite, regdst, ALUsrc, ALUop,
    output pc4_id, rdata1_id, rdata2_id, imm_id,
    output rs_id, rt_id, rd_id, funct_id,
    input  write_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex, regdst_ex, ALUsrc_ex,
    input  ALUop_ex, pc4_ex, rdata1_ex, rdata2_ex, imm_ex,
    input  rs_ex, rt_ex, rd_ex, funct_ex, valid_ex,
    input  load_use_stall, stall_count
  );

  // Pipeline register: consumes ID fields, produces EX fields
  modport slave (
    input  flush, hold, valid_id,
    input  write, MemtoReg, MemRead, MemWrite, regdst, ALUsrc, ALUop,
    input  pc4_id, rdata1_id, rdata2_id, imm_id,
    input  rs_id, rt_id, rd_id, funct_id,
    output write_ex, MemtoReg_ex, MemRead_ex, MemWrite_ex, regdst_ex, ALUsrc_ex,
    output ALUop_ex, pc4_ex, rdata1_ex, rdata2_ex, imm_ex,
    output rs_ex, rt_ex, rd_ex, funct_ex, valid_ex,
    output load_use_stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with a built-in load-use hazard detector.
//   Captures the stall-gated control bundle and ID datapath fields and
//   presents them to EX one cycle later. Generates load_use_stall, which
//   gates the ID control mux and freezes PC and IF/ID.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - id_ex_stage_if.slave (ID inputs, EX outputs, stall, counter)
//
//   Update priority per edge: rst > flush > hold > load_use_stall > load.
//   A "bubble" is all 1-bit controls 0, ALUop 2'b11, valid 0.
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  id_ex_stage_if.slave   bus
);

  localparam logic [1:0]       ALUOP_BUBBLE = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  // Control flops
  logic             write_q,     write_d;
  logic             memtoreg_q,  memtoreg_d;
  logic             memread_q,   memread_d;
  logic             memwrite_q,  memwrite_d;
  logic             regdst_q,    regdst_d;
  logic             alusrc_q,    alusrc_d;
  logic [1:0]       aluop_q,     aluop_d;
  logic             valid_q,     valid_d;

  // Datapath flops
  logic [DW-1:0]    pc4_q,       pc4_d;
  logic [DW-1:0]    rdata1_q,    rdata1_d;
  logic [DW-1:0]    rdata2_q,    rdata2_d;
  logic [DW-1:0]    imm_q,       imm_d;
  logic [4:0]       rs_q,        rs_d;
  logic [4:0]       rt_q,        rt_d;
  logic [4:0]       rd_q,        rd_d;
  logic [5:0]       funct_q,     funct_d;

  // Performance counter
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Hazard result
  logic             load_use_stall_s;
  logic             rt_hit_s;

  // Load-use detection: uses only registered EX state plus raw ID specifiers,
  // so there is no path from the control mux back into this equation.
  always_comb begin
    rt_hit_s         = (rt_q == bus.rs_id) | (rt_q == bus.rt_id);
    load_use_stall_s = valid_q & memread_q & (rt_q != 5'd0) & bus.valid_id & rt_hit_s;
  end

  // Next-state selection for the pipeline register (rst handled in the flop block)
  always_comb begin
    write_d    = write_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    regdst_d   = regdst_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    valid_d    = valid_q;
    pc4_d      = pc4_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    funct_d    = funct_q;

    if (bus.flush) begin
      // Squash: full bubble with cleared datapath
      write_d    = 1'b0;
      memtoreg_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      regdst_d   = 1'b0;
      alusrc_d   = 1'b0;
      aluop_d    = ALUOP_BUBBLE;
      valid_d    = 1'b0;
      pc4_d      = {DW{1'b0}};
      rdata1_d   = {DW{1'b0}};
      rdata2_d   = {DW{1'b0}};
      imm_d      = {DW{1'b0}};
      rs_d       = 5'd0;
      rt_d       = 5'd0;
      rd_d       = 5'd0;
      funct_d    = 6'd0;
    end else if (bus.hold) begin
      // Freeze: defaults already hold every field
      valid_d    = valid_q;
    end else if (load_use_stall_s) begin
      // Bubble controls; datapath still follows ID (don't-care for a bubble).
      // Redundant with the control mux gating on purpose, so a mux fault
      // cannot leak a live instruction into EX during a stall.
      write_d    = 1'b0;
      memtoreg_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      regdst_d   = 1'b0;
      alusrc_d   = 1'b0;
      aluop_d    = ALUOP_BUBBLE;
      valid_d    = 1'b0;
      pc4_d      = bus.pc4_id;
      rdata1_d   = bus.rdata1_id;
      rdata2_d   = bus.rdata2_id;
      imm_d      = bus.imm_id;
      rs_d       = bus.rs_id;
      rt_d       = bus.rt_id;
      rd_d       = bus.rd_id;
      funct_d    = bus.funct_id;
    end else begin
      // Normal advance from ID to EX
      write_d    = bus.write;
      memtoreg_d = bus.MemtoReg;
      memread_d  = bus.MemRead;
      memwrite_d = bus.MemWrite;
      regdst_d   = bus.regdst;
      alusrc_d   = bus.ALUsrc;
      aluop_d    = bus.ALUop;
      valid_d    = bus.valid_id;
      pc4_d      = bus.pc4_id;
      rdata1_d   = bus.rdata1_id;
      rdata2_d   = bus.rdata2_id;
      imm_d      = bus.imm_id;
      rs_d       = bus.rs_id;
      rt_d       = bus.rt_id;
      rd_d       = bus.rd_id;
      funct_d    = bus.funct_id;
    end
  end

  // Bubble counter: counts only bubbles actually inserted by the hazard,
  // not flushes and not cycles frozen by hold; saturates instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (load_use_stall_s & ~bus.hold & ~bus.flush & (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State register with synchronous reset to the bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q       <= 1'b0;
      memtoreg_q    <= 1'b0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      regdst_q      <= 1'b0;
      alusrc_q      <= 1'b0;
      aluop_q       <= ALUOP_BUBBLE;
      valid_q       <= 1'b0;
      pc4_q         <= {DW{1'b0}};
      rdata1_q      <= {DW{1'b0}};
      rdata2_q      <= {DW{1'b0}};
      imm_q         <= {DW{1'b0}};
      rs_q          <= 5'd0;
      rt_q          <= 5'd0;
      rd_q          <= 5'd0;
      funct_q       <= 6'd0;
      stall_count_q <= {CNT_W{1'b0}};
    end else begin
      write_q       <= write_d;
      memtoreg_q    <= memtoreg_d;
      memread_q     <= memread_d;
      memwrite_q    <= memwrite_d;
      regdst_q      <= regdst_d;
      alusrc_q      <= alusrc_d;
      aluop_q       <= aluop_d;
      valid_q       <= valid_d;
      pc4_q         <= pc4_d;
      rdata1_q      <= rdata1_d;
      rdata2_q      <= rdata2_d;
      imm_q         <= imm_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rd_q          <= rd_d;
      funct_q       <= funct_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Output mapping
  assign bus.write_ex       = write_q;
  assign bus.MemtoReg_ex    = memtoreg_q;
  assign bus.MemRead_ex     = memread_q;
  assign bus.MemWrite_ex    = memwrite_q;
  assign bus.regdst_ex      = regdst_q;
  assign bus.ALUsrc_ex      = alusrc_q;
  assign bus.ALUop_ex       = aluop_q;
  assign bus.valid_ex       = valid_q;
  assign bus.pc4_ex         = pc4_q;
  assign bus.rdata1_ex      = rdata1_q;
  assign bus.rdata2_ex      = rdata2_q;
  assign bus.imm_ex         = imm_q;
  assign bus.rs_ex          = rs_q;
  assign bus.rt_ex          = rt_q;
  assign bus.rd_ex          = rd_q;
  assign bus.funct_ex       = funct_q;
  assign bus.load_use_stall = load_use_stall_s;
  assign bus.stall_count    = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Scoreboard bench: the driver applies ID inputs on the falling edge,
//   advances a slot-level reference model and pushes the expected response;
//   a monitor samples the stall mid-cycle and the EX slot after each rising
//   edge, popping and comparing. The counter is 4 bits so saturation is hit.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  typedef struct {
    logic          wr, m2r, mrd, mwr, rdst, asrc;
    logic [1:0]    aop;
    logic [DW-1:0] pc4, rd1, rd2, imm;
    logic [4:0]    rs, rt, rd;
    logic [5:0]    fn;
    logic          vld;
  } slot_t;

  typedef struct {
    bit    chk_stall;
    logic  stall;
    bit    chk_state;
    slot_t ex;
    int    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];

  // reference model state: what the EX slot should hold
  slot_t m_ex;
  bit    m_known = 1'b0;
  int    m_cnt   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic slot_t bubble();
    slot_t b;
    b = '{default: '0};
    b.aop = 2'b11;
    return b;
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.wr   = 1'($urandom);
    s.m2r  = 1'($urandom);
    s.mrd  = 1'($urandom);
    s.mwr  = 1'($urandom);
    s.rdst = 1'($urandom);
    s.asrc = 1'($urandom);
    s.aop  = 2'($urandom);
    s.pc4  = DW'($urandom);
    s.rd1  = DW'($urandom);
    s.rd2  = DW'($urandom);
    s.imm  = DW'($urandom);
    s.rs   = 5'($urandom_range(0, 7));
    s.rt   = 5'($urandom_range(0, 7));
    s.rd   = 5'($urandom);
    s.fn   = 6'($urandom);
    s.vld  = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
    return s;
  endfunction

  // a lw writing register rt
  function automatic slot_t mk_lw(input logic [4:0] rt);
    slot_t s;
    s = rand_slot();
    s.vld = 1'b1; s.mrd = 1'b1; s.rt = rt; s.rs = 5'd1;
    return s;
  endfunction

  // a valid non-load instruction with given sources
  function automatic slot_t mk_op(input logic [4:0] rs, input logic [4:0] rt);
    slot_t s;
    s = rand_slot();
    s.vld = 1'b1; s.mrd = 1'b0; s.rs = rs; s.rt = rt;
    return s;
  endfunction

  // One cycle: apply inputs, advance the model, push the expectation
  task automatic step(input slot_t id, input logic r, input logic f, input logic h);
    exp_t e;
    bool_stall: begin end
    @(negedge clk);
    rst          = r;
    bus.flush    = f;
    bus.hold     = h;
    bus.valid_id = id.vld;
    bus.write    = id.wr;
    bus.MemtoReg = id.m2r;
    bus.MemRead  = id.mrd;
    bus.MemWrite = id.mwr;
    bus.regdst   = id.rdst;
    bus.ALUsrc   = id.asrc;
    bus.ALUop    = id.aop;
    bus.pc4_id   = id.pc4;
    bus.rdata1_id = id.rd1;
    bus.rdata2_id = id.rd2;
    bus.imm_id   = id.imm;
    bus.rs_id    = id.rs;
    bus.rt_id    = id.rt;
    bus.rd_id    = id.rd;
    bus.funct_id = id.fn;

    // a load in EX whose target is a nonzero source of a real ID instruction
    e.chk_stall = m_known;
    e.stall = m_known && m_ex.vld && m_ex.mrd && (m_ex.rt != 5'd0) && id.vld &&
              ((m_ex.rt == id.rs) || (m_ex.rt == id.rt));

    if (r) begin
      m_ex = bubble(); m_cnt = 0; m_known = 1'b1;
    end else if (f) begin
      m_ex = bubble();
    end else if (h) begin
      m_ex = m_ex;
    end else if (e.stall) begin
      // bubble controls, datapath from ID
      m_ex = id;
      m_ex.wr = 1'b0; m_ex.m2r = 1'b0; m_ex.mrd = 1'b0; m_ex.mwr = 1'b0;
      m_ex.rdst = 1'b0; m_ex.asrc = 1'b0; m_ex.aop = 2'b11; m_ex.vld = 1'b0;
      if (m_cnt < CMAX) m_cnt = m_cnt + 1;
    end else begin
      m_ex = id;
    end
    e.chk_state = m_known;
    e.ex  = m_ex;
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: stall mid-low-phase, EX slot just after the rising edge
  initial begin : monitor
    logic st;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      st = bus.load_use_stall;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk_stall) chk("load_use_stall", 64'(st), 64'(e.stall));
        if (e.chk_state) begin
          chk("valid_ex",    64'(bus.valid_ex),    64'(e.ex.vld));
          chk("write_ex",    64'(bus.write_ex),    64'(e.ex.wr));
          chk("MemtoReg_ex", 64'(bus.MemtoReg_ex), 64'(e.ex.m2r));
          chk("MemRead_ex",  64'(bus.MemRead_ex),  64'(e.ex.mrd));
          chk("MemWrite_ex", 64'(bus.MemWrite_ex), 64'(e.ex.mwr));
          chk("regdst_ex",   64'(bus.regdst_ex),   64'(e.ex.rdst));
          chk("ALUsrc_ex",   64'(bus.ALUsrc_ex),   64'(e.ex.asrc));
          chk("ALUop_ex",    64'(bus.ALUop_ex),    64'(e.ex.aop));
          chk("pc4_ex",      64'(bus.pc4_ex),      64'(e.ex.pc4));
          chk("rdata1_ex",   64'(bus.rdata1_ex),   64'(e.ex.rd1));
          chk("rdata2_ex",   64'(bus.rdata2_ex),   64'(e.ex.rd2));
          chk("imm_ex",      64'(bus.imm_ex),      64'(e.ex.imm));
          chk("rs_ex",       64'(bus.rs_ex),       64'(e.ex.rs));
          chk("rt_ex",       64'(bus.rt_ex),       64'(e.ex.rt));
          chk("rd_ex",       64'(bus.rd_ex),       64'(e.ex.rd));
          chk("funct_ex",    64'(bus.funct_ex),    64'(e.ex.fn));
          chk("stall_count", 64'(bus.stall_count), 64'(e.cnt));
        end
      end
    end
  end

  initial begin : driver
    slot_t dep;
    rst = 1'b1;
    bus.flush = 1'b0; bus.hold = 1'b0;

    // reset for two cycles with random ID inputs
    step(rand_slot(), 1'b1, 1'b0, 1'b0);
    step(rand_slot(), 1'b1, 1'b0, 1'b0);

    // basic load-use: one stall, one bubble, then the dependent instruction
    step(mk_lw(5'd5), 1'b0, 1'b0, 1'b0);
    dep = mk_op(5'd5, 5'd9);
    step(dep, 1'b0, 1'b0, 1'b0);
    step(dep, 1'b0, 1'b0, 1'b0);
    step(mk_op(5'd2, 5'd3), 1'b0, 1'b0, 1'b0);

    // no false stall: $zero target, and non-matching sources
    step(mk_lw(5'd0), 1'b0, 1'b0, 1'b0);
    step(mk_op(5'd0, 5'd0), 1'b0, 1'b0, 1'b0);
    step(mk_lw(5'd5), 1'b0, 1'b0, 1'b0);
    step(mk_op(5'd6, 5'd7), 1'b0, 1'b0, 1'b0);
    #3 chk("no_false_stall_rs6_rt7", 64'(bus.load_use_stall), 64'd0);

    // hold for 3 cycles during a pending hazard, then release
    step(mk_lw(5'd4), 1'b0, 1'b0, 1'b0);
    dep = mk_op(5'd8, 5'd4);
    repeat (3) step(dep, 1'b0, 1'b0, 1'b1);
    step(dep, 1'b0, 1'b0, 1'b0);
    step(dep, 1'b0, 1'b0, 1'b0);

    // flush together with hold and a pending hazard
    step(mk_lw(5'd3), 1'b0, 1'b0, 1'b0);
    dep = mk_op(5'd3, 5'd3);
    step(dep, 1'b0, 1'b1, 1'b1);
    step(dep, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a stall
    step(mk_lw(5'd6), 1'b0, 1'b0, 1'b0);
    dep = mk_op(5'd6, 5'd1);
    step(dep, 1'b1, 1'b0, 1'b0);
    step(dep, 1'b0, 1'b0, 1'b0);

    // saturation: 20 load-use bubbles on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(mk_lw(5'd5), 1'b0, 1'b0, 1'b0);
      dep = mk_op(5'd5, 5'd2);
      step(dep, 1'b0, 1'b0, 1'b0);
      step(dep, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    chk("stall_count_saturated", 64'(bus.stall_count), 64'd15);

    // randomized traffic, occasionally re-presenting a stalled instruction
    dep = rand_slot();
    for (int i = 0; i < 600; i++) begin
      logic r, f, h;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 8);
      h = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 1) == 0) dep = rand_slot();
      step(dep, r, f, h);
    end

    // drain
    @(negedge clk);
    @(posedge clk); #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage core, with the load-use hazard detector built in. The register captures the stall-gated control bundle produced by the ID-stage control mux, along with the ID datapath fields, and presents them to EX one cycle later. The block also generates the `load_use_stall` that drives that control mux and freezes PC and IF/ID. This makes it the direct consumer of the control mux and the source of its `stall` input.

## Interface
Parameters:
- `DW`, 32: datapath width for PC+4, register read data and immediate.
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `flush`, input, 1: squash the ID instruction (taken branch or jump).
- `hold`, input, 1: back-pressure from downstream; freezes the register.
- `valid_id`, input, 1: the IF/ID slot holds a real instruction.
- `write`, `MemtoReg`, `MemRead`, `MemWrite`, `regdst`, `ALUsrc`, input, 1 each: stall-gated control bits from the control mux.
- `ALUop`, input, 2: stall-gated ALU operation class.
- `pc4_id`, `rdata1_id`, `rdata2_id`, `imm_id`, input, DW each.
- `rs_id`, `rt_id`, `rd_id`, input, 5 each.
- `funct_id`, input, 6.
- `*_ex`, output: registered copies of every control and data input above, for example `write_ex`, `ALUop_ex`, `rt_ex`.
- `valid_ex`, output, 1: EX slot holds a real instruction.
- `load_use_stall`, output, 1: combinational; drives the control mux `stall`, PC write-disable and IF/ID write-disable.
- `stall_count`, output, CNT_W: saturating count of inserted bubbles.

## Operation
- **Hazard detection.** `load_use_stall = valid_ex & MemRead_ex & (rt_ex != 0) & valid_id & ((rt_ex == rs_id) | (rt_ex == rt_id))`.
  - The equation depends only on registered EX state and ID fields, so there is no combinational loop through the control mux.
- **Update priority each rising edge:** rst > flush > hold > load_use_stall > normal load.
- **rst or flush:** load the bubble.
  - Bubble: all 1-bit control fields = 0, `ALUop_ex` = 2'b11, `valid_ex` = 0.
  - Data fields and register specifiers are cleared to 0.
- **hold:** every field, including `valid_ex`, keeps its value.
- **load_use_stall (no hold):** load the bubble.
  - Data fields still load from the inputs, but only the control bits matter.
  - This is deliberately redundant with the control mux gating.
- **Normal:** every `*_ex` field takes its ID input, and `valid_ex <= valid_id`.
- **stall_count:**
  - Increments on each edge where `load_use_stall & ~hold & ~flush & ~rst`.
  - Saturates at all-ones.
  - Cleared only by rst.

## Timing
- Latency: one cycle from ID inputs to `*_ex` outputs.
- Reset values: every `*_ex` output = 0, except `ALUop_ex` = 2'b11. `valid_ex` = 0, `stall_count` = 0. `load_use_stall` = 0 (follows from `valid_ex` = 0).
- **Load-use sequence.**
  - Cycle n: lw is in EX and the dependent instruction is in ID, so `load_use_stall` = 1.
  - Cycle n+1: EX holds the bubble, the dependent instruction is still in ID, and `load_use_stall` = 0.
  - Cycle n+2: the dependent instruction enters EX. Exactly one bubble is inserted.
- **hold with a pending hazard:** the lw stays in EX, so `load_use_stall` stays 1 for the whole hold. No bubble is inserted and the counter does not increment until hold drops.
- **flush with a pending hazard:** flush wins and a bubble is loaded. The counter does not increment.
- **rt_ex = 0:** never stalls (a $zero destination).
- **Reset mid-stall:** next cycle all state is at reset values and the stall deasserts.

## Test plan
- **Reset:** assert rst for 2 cycles with random inputs → all `*_ex` = 0, `ALUop_ex` = 2'b11, `valid_ex` = 0, `stall_count` = 0.
- **Load-use:**
  - Stimulus: lw with rt=5 loaded into EX, then ID presents rs_id=5, valid_id=1.
  - Required: `load_use_stall` = 1 for exactly one cycle, then a bubble in EX with `ALUop_ex` = 2'b11 and `stall_count` = 1, then the dependent instruction in EX.
- **No false stall:** lw with rt=0 and ID rs=0 → `load_use_stall` = 0. lw rt=5 with ID rs=6, rt=7 → 0.
- **hold during hazard:** hold=1 for 3 cycles while the hazard is pending → `*_ex` unchanged, `load_use_stall` = 1 throughout, `stall_count` unchanged. After release, one bubble and the count increments by 1.
- **flush vs. hold/hazard:** flush=1 together with hold=1 and a pending hazard → bubble loaded, `valid_ex` = 0, counter unchanged.
- **Saturation:** with `CNT_W` = 4, force 20 load-use stalls → `stall_count` stops at 15.
